// File: rtl/if_unit_if.sv
// if_unit_if: instruction-memory req/ack fetch bus between if_unit and imem
interface if_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_unit.sv
// if_unit: MIPS fetch front end owning PC/IR, fetching over req/ack and selecting next PC
module if_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    if_unit_if.master   imem,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] retired_cnt
);
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    state_t      state, state_n;
    logic [31:0] next_pc;
    logic        commit, misaligned;
    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_req  = state == FETCH;
    assign imem.imem_addr = pc;
    assign instr_valid    = state == EXEC;
    assign fetch_err      = state == HALT;
    assign commit         = instr_valid && instr_ready;
    assign misaligned     = next_pc[1:0] != 2'b00;
    always_comb begin
        next_pc = npc_op == 2'b00 ? pc_plus4 :
                  npc_op == 2'b01 ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00} :
                  npc_op == 2'b10 ? {pc_plus4[31:28], instr[25:0], 2'b00} : rs_data;
        state_n = state == FETCH ? (imem.imem_ack ? EXEC : FETCH) :
                  state == EXEC  ? (instr_ready ? (misaligned ? HALT : FETCH) : EXEC) : HALT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH && imem.imem_ack)
                instr <= imem.imem_rdata;
            // a misaligned target still retires the instruction but keeps pc
            if (commit) begin
                retired_cnt <= retired_cnt + 32'd1;
                if (!misaligned)
                    pc <= next_pc;
            end
        end
    end
endmodule

// File: tb/tb_if_unit.sv
// tb_if_unit: table-driven checks of fetch, stall, next-PC selection, halt and reset aborts
module tb_if_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        instr_ready = 0;
    logic [1:0]  npc_op = 0;
    logic [31:0] rs_data = 0;
    logic [31:0] instr, pc, pc_plus4, retired_cnt;
    logic        instr_valid, fetch_err;
    int          tests = 0;
    int          fails = 0;

    if_unit_if bus();

    if_unit dut (
        .clk(clk), .rst(rst), .imem(bus), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .npc_op(npc_op), .rs_data(rs_data), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_err(fetch_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  op;
        logic [31:0] rs;
        int          waits;
        int          stalls;
        logic [31:0] next;
        logic        halt;
    } vec_t;

    vec_t v[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_exec(input logic [31:0] rdata, input int waits, input int stalls,
                              input logic [1:0] op, input logic [31:0] rs,
                              input logic [31:0] pc_exp, input logic [31:0] cnt_exp);
        for (int w = 0; w <= waits; w++) begin
            check("imem_req", 32'(bus.imem_req), 1);
            check("imem_addr", bus.imem_addr, pc_exp);
            check("valid_in_fetch", 32'(instr_valid), 0);
            bus.imem_ack   = (w == waits);
            bus.imem_rdata = rdata;
            tick;
        end
        bus.imem_ack = 0;
        for (int s = 0; s <= stalls; s++) begin
            check("instr_valid", 32'(instr_valid), 1);
            check("instr", instr, rdata);
            check("pc", pc, pc_exp);
            check("pc_plus4", pc_plus4, pc_exp + 32'd4);
            check("retired_hold", retired_cnt, cnt_exp);
            instr_ready = (s == stalls);
            npc_op      = op;
            rs_data     = rs;
            tick;
        end
        instr_ready = 0;
        npc_op      = 0;
        rs_data     = 0;
    endtask

    initial begin
        logic [31:0] p;
        bus.imem_ack   = 0;
        bus.imem_rdata = 0;
        v[0] = '{32'h2008_0005, 2'b00, 32'h0,         0, 0, 32'h0000_3004, 1'b0};
        v[1] = '{32'h0000_0000, 2'b00, 32'h0,         0, 0, 32'h0000_3008, 1'b0};
        v[2] = '{32'h8C01_0004, 2'b00, 32'h0,         3, 4, 32'h0000_300C, 1'b0};
        v[3] = '{32'h0000_0020, 2'b00, 32'h0,         1, 1, 32'h0000_3010, 1'b0};
        v[4] = '{32'h1000_FFFF, 2'b01, 32'h0,         0, 0, 32'h0000_3010, 1'b0};
        v[5] = '{32'h0800_0C00, 2'b10, 32'h0,         0, 0, 32'h0000_3000, 1'b0};
        v[6] = '{32'h03E0_0008, 2'b11, 32'h0000_3040, 0, 0, 32'h0000_3040, 1'b0};
        v[7] = '{32'h03E0_0008, 2'b11, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1'b0};
        v[8] = '{32'h0000_0000, 2'b00, 32'h0,         0, 0, 32'h0000_0000, 1'b0};
        v[9] = '{32'h03E0_0008, 2'b11, 32'h0000_3042, 0, 0, 32'h0000_0000, 1'b1};
        tick;
        tick;
        rst = 0;
        check("rst_req", 32'(bus.imem_req), 1);
        check("rst_addr", bus.imem_addr, 32'h0000_3000);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_retired", retired_cnt, 0);
        check("rst_err", 32'(fetch_err), 0);
        check("rst_instr", instr, 0);
        p = 32'h0000_3000;
        for (int i = 0; i < 10; i++) begin
            fetch_exec(v[i].rdata, v[i].waits, v[i].stalls, v[i].op, v[i].rs, p, 32'(i));
            check("retired_after", retired_cnt, 32'(i + 1));
            check("halt_state", 32'(fetch_err), 32'(v[i].halt));
            check("valid_after", 32'(instr_valid), 0);
            check("req_after", 32'(bus.imem_req), 32'(!v[i].halt));
            check("pc_after", pc, v[i].next);
            p = v[i].next;
        end
        bus.imem_ack = 1;
        instr_ready  = 1;
        tick;
        tick;
        bus.imem_ack = 0;
        instr_ready  = 0;
        check("halt_sticky_err", 32'(fetch_err), 1);
        check("halt_sticky_req", 32'(bus.imem_req), 0);
        check("halt_sticky_valid", 32'(instr_valid), 0);
        check("halt_sticky_pc", pc, 32'h0);
        check("halt_sticky_cnt", retired_cnt, 32'd10);
        rst = 1;
        tick;
        rst = 0;
        check("unhalt_err", 32'(fetch_err), 0);
        check("unhalt_req", 32'(bus.imem_req), 1);
        check("unhalt_pc", pc, 32'h0000_3000);
        check("unhalt_cnt", retired_cnt, 0);
        fetch_exec(32'h2008_0005, 0, 0, 2'b00, 32'h0, 32'h0000_3000, 0);
        fetch_exec(32'h0000_0000, 0, 0, 2'b00, 32'h0, 32'h0000_3004, 1);
        check("pre_wait_addr", bus.imem_addr, 32'h0000_3008);
        tick;
        rst            = 1;
        bus.imem_ack   = 1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick;
        rst          = 0;
        bus.imem_ack = 0;
        check("rstwait_instr", instr, 0);
        check("rstwait_pc", pc, 32'h0000_3000);
        check("rstwait_valid", 32'(instr_valid), 0);
        check("rstwait_cnt", retired_cnt, 0);
        bus.imem_ack   = 1;
        bus.imem_rdata = 32'h03E0_0008;
        tick;
        bus.imem_ack = 0;
        check("rstexec_valid_pre", 32'(instr_valid), 1);
        rst         = 1;
        instr_ready = 1;
        npc_op      = 2'b11;
        rs_data     = 32'h0000_3040;
        tick;
        rst         = 0;
        instr_ready = 0;
        check("rstexec_pc", pc, 32'h0000_3000);
        check("rstexec_cnt", retired_cnt, 0);
        check("rstexec_valid", 32'(instr_valid), 0);
        check("rstexec_instr", instr, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if_unit.md
# if_unit

Instruction-fetch front end for the MIPS CPU, directly upstream of the `ctrl` decoder. It owns the PC register and fetches words from instruction memory over a req/ack handshake. It presents the fetched instruction (Op = `instr[31:26]`, Funct = `instr[5:0]`) to `ctrl` and the datapath, and computes the next PC from the `NPCOp` that `ctrl` returns. Each fetch takes at least two cycles, so the block tolerates memories with wait states.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC loaded on reset.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_req`, out, 1: fetch request; held high until `imem_ack`.
- `imem_addr`, out, 32: byte address of the fetch, equal to `pc`.
- `imem_ack`, in, 1: memory has returned `imem_rdata` this cycle.
- `imem_rdata`, in, 32: instruction word.
- `instr`, out, 32: latched instruction register (IR).
- `instr_valid`, out, 1: `instr` and `pc` describe the instruction currently executing.
- `instr_ready`, in, 1: datapath commits the current instruction this cycle.
- `npc_op`, in, 2: next-PC select. `00` = PLUS4, `01` = BRANCH, `10` = JUMP, `11` = JR (register).
- `rs_data`, in, 32: GPR[rs], the target for JR.
- `pc`, out, 32: address of the instruction in IR.
- `pc_plus4`, out, 32: `pc + 4`, used as the jal link value.
- `fetch_err`, out, 1: misaligned next PC detected; the block is halted.
- `retired_cnt`, out, 32: count of committed instructions.

## Operation
States:
- **FETCH**
  - Drives `imem_req=1` and `imem_addr=pc`.
  - On `imem_ack`: IR <= `imem_rdata`, go to EXEC.
  - Otherwise stay in FETCH.
- **EXEC**
  - Drives `instr_valid=1`; IR and `pc` are stable.
  - On `instr_ready`: `pc <= next_pc`, `retired_cnt <= retired_cnt+1`, go to FETCH.
  - If `next_pc[1:0] != 0`: do not update `pc`, still increment `retired_cnt`, go to HALT.
- **HALT**
  - Drives `fetch_err=1`, `imem_req=0`, `instr_valid=0`.
  - Leaves HALT only on `rst`.

next_pc selection, all arithmetic 32-bit modulo 2^32 (wrap silently):
- PLUS4: `pc + 4`.
- BRANCH: `pc + 4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
- JUMP: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- JR: `rs_data`.

Other rules:
- `pc_plus4` is combinational from `pc`.
- `imem_ack` is ignored outside FETCH.
- `instr_ready` is ignored outside EXEC.
- `npc_op` and `rs_data` are sampled only in the EXEC cycle where `instr_ready=1`.

## Timing
Reset (`rst` high at an edge), from the next cycle:
- state = FETCH, `pc = RESET_PC`, IR = 0, `retired_cnt` = 0.
- `instr_valid` = 0, `fetch_err` = 0.
- `imem_req` = 1, `imem_addr` = `RESET_PC`.

Latency and throughput:
- With zero-wait memory (`imem_ack` in the first FETCH cycle), each instruction takes exactly 2 cycles: FETCH, then EXEC.
- Each wait cycle adds one FETCH cycle.
- Each cycle with `instr_ready=0` adds one EXEC cycle.
- `imem_req` and `imem_addr` stay stable from assertion until ack.

Boundary conditions:
- Reset mid-fetch or mid-EXEC aborts the operation: IR is not updated, `retired_cnt` is not incremented, and the PC update is discarded. Instruction memory shares `rst` and drops any pending request.
- `rst` and `imem_ack` in the same cycle: reset wins.
- `rst` and `instr_ready` in the same cycle: reset wins.
- `retired_cnt` wraps from `32'hFFFF_FFFF` to 0.
- PC wraps: `pc=32'hFFFF_FFFC` with PLUS4 gives `32'h0000_0000`, which is legal and not an error.
- The misalignment check applies to all four `npc_op` values; in practice only JR can produce a misaligned target.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then release.
  - Required: `imem_req=1` and `imem_addr=32'h3000` in the first cycle after release.
  - Required: `instr_valid=0`, `retired_cnt=0`, `fetch_err=0`.
- **Sequential fetch:** zero-wait memory returns `32'h2008_0005` at `3000` and `32'h0000_0000` at `3004`; hold `instr_ready=1` and `npc_op=00`.
  - Required: `instr_valid` pulses every other cycle.
  - Required: `pc` runs `3000`, `3004`, `3008`.
  - Required: `retired_cnt=2` after the second commit.
- **Wait states and stall:** `imem_ack` delayed 3 cycles, then `instr_ready` held low for 4 cycles.
  - Required: `imem_addr` stays stable for 4 cycles.
  - Required: IR is held and `retired_cnt` is unchanged until commit.
- **Branch and jump targets:**
  - At `pc=32'h3010`, `instr=32'h1000_FFFF` with `npc_op=01`: required next `pc=32'h3010`.
  - `instr=32'h0800_0C00` with `npc_op=10`: required next `pc=32'h0000_3000`.
- **JR and misalignment:**
  - `npc_op=11` with `rs_data=32'h0000_3040`: required next `pc=32'h3040`.
  - `npc_op=11` with `rs_data=32'h0000_3042`: required state HALT, `fetch_err=1`, `imem_req=0`, `pc` unchanged; a later `rst` clears the halt.
- **Reset during wait:** assert `rst` in the second cycle of a pending fetch at `32'h3008`, with a late `imem_ack` in the same cycle.
  - Required: IR stays 0 and `pc=32'h3000` the following cycle.
